// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC generator.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int PC_STEP = 4;

    // Redirect source indices; lower index wins when several fire together.
    localparam int REDIR_TRAP   = 0;
    localparam int REDIR_BRANCH = 1;
    localparam int REDIR_JUMP   = 2;

endpackage

// File: rtl/fetch_pc_gen_redirect_arbiter.sv
// Redirect arbiter: combinational lowest-index-wins select over the
// redirect sources. Losing requests are dropped, not queued.
module redirect_arbiter
    import fetch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_REDIR = 3
) (
    input  logic [NUM_REDIR-1:0]      redirect_valid,
    input  logic [NUM_REDIR*XLEN-1:0] redirect_pc,
    output logic                      any_valid,
    output logic [XLEN-1:0]           sel_pc
);

    assign any_valid = |redirect_valid;

    // Walk from the highest index down so the lowest set index is written last.
    always_comb begin
        sel_pc = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redirect_valid[i]) begin
                sel_pc = redirect_pc[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage program-counter generator with valid/ready request port,
// prioritised redirects, wrapping epoch tag and boot/run/halt sequencing.
// Optional build macro: MISALIGN_TRAP_EN (trap misaligned redirect targets
// to TRAP_PC instead of silently aligning them).
//
// state  | meaning
// BOOT   | one cycle after reset, no requests issued
// RUN    | issuing fetch requests unless stalled or halt requested
// HALTED | fetch stopped while halt_req is held
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int             XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int             NUM_REDIR = 3,
    parameter int             EPOCH_W   = 2,
    parameter logic [XLEN-1:0] TRAP_PC  = 32'h0000_0010
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      halt_req,
    input  logic [NUM_REDIR-1:0]      redirect_valid,
    input  logic [NUM_REDIR*XLEN-1:0] redirect_pc,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic [XLEN-1:0]           req_pc,
    output logic [EPOCH_W-1:0]        req_epoch,
    output logic                      flush,
    output logic                      halted,
    output logic                      misalign_valid,
    output logic [XLEN-1:0]           misalign_addr
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic            any_valid;
    logic [XLEN-1:0] sel_pc;
    logic [XLEN-1:0] redir_target;
    logic            fire;

    redirect_arbiter #(
        .XLEN      (XLEN),
        .NUM_REDIR (NUM_REDIR)
    ) u_arb (
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .any_valid      (any_valid),
        .sel_pc         (sel_pc)
    );

`ifdef MISALIGN_TRAP_EN
    logic misaligned;

    assign misaligned   = (sel_pc[1:0] != 2'b00);
    assign redir_target = misaligned ? TRAP_PC : sel_pc;

    // Record the offending target whenever a misaligned redirect is trapped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_valid <= 1'b0;
            misalign_addr  <= '0;
        end else begin
            misalign_valid <= any_valid & misaligned;
            if (any_valid & misaligned) begin
                misalign_addr <= sel_pc;
            end
        end
    end
`else
    logic unused_trap_bits;

    // Targets are word-aligned by dropping the low bits; no trap reporting.
    assign redir_target     = {sel_pc[XLEN-1:2], 2'b00};
    assign misalign_valid   = 1'b0;
    assign misalign_addr    = '0;
    assign unused_trap_bits = ^{TRAP_PC, sel_pc[1:0]};
`endif

    assign req_valid = (state_q == RUN) & ~stall & ~halt_req;
    assign fire      = req_valid & req_ready;
    assign halted    = (state_q == HALTED);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for boot/run/halt sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt_req)  state_d = HALTED;
            HALTED:  if (!halt_req) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // PC, epoch and flush: a redirect beats stall and handshake in any state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_pc    <= RESET_PC;
            req_epoch <= '0;
            flush     <= 1'b0;
        end else begin
            flush <= any_valid;
            if (any_valid) begin
                req_pc    <= redir_target;
                req_epoch <= req_epoch + EPOCH_W'(1);
            end else if (!stall && fire) begin
                req_pc <= req_pc + XLEN'(PC_STEP);
            end
        end
    end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Parametrised program-counter generator for the fetch stage. It replaces the single-redirect PC register with a valid/ready instruction-memory request port, N prioritised redirect sources and a boot/run/halt state machine. A wrapping epoch tag lets downstream stages squash fetches issued before a redirect. It sits between the core's control/redirect logic and the instruction-memory interface.

## Interface
Parameters:
- XLEN, 32, address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NUM_REDIR, 3, number of redirect sources; index 0 has highest priority.
- EPOCH_W, 2, width of the epoch tag.
- TRAP_PC, 32'h0000_0010, target used for a misaligned redirect (only with MISALIGN_TRAP_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  1  downstream stall; hold PC and suppress requests.
- halt_req  in  1  level request to stop fetching.
- redirect_valid  in  NUM_REDIR  per-source redirect strobe.
- redirect_pc  in  NUM_REDIR*XLEN  per-source target; source i occupies bits [i*XLEN +: XLEN].
- req_valid  out  1  fetch request valid.
- req_ready  in  1  instruction memory accepts the request.
- req_pc  out  XLEN  fetch address.
- req_epoch  out  EPOCH_W  epoch tag carried with the request.
- flush  out  1  one-cycle pulse after any applied redirect.
- halted  out  1  high in the HALTED state.
- misalign_valid  out  1  one-cycle pulse; misaligned redirect trapped.
- misalign_addr  out  XLEN  offending target, held until the next trap.

## Operation
- States: BOOT, RUN, HALTED. Reset enters BOOT.
- Transitions:
  - BOOT to RUN after one cycle, unconditionally.
  - RUN to HALTED when halt_req is 1.
  - HALTED to RUN when halt_req is 0.
- Output: req_valid = (state==RUN) & !stall & !halt_req, combinational.
- fire = req_valid & req_ready.
- PC update priority, per cycle:
  1. Any redirect_valid: req_pc <= target of the lowest set index. Applies in every state, regardless of stall or ready.
  2. Else if stall: hold.
  3. Else if fire: req_pc <= req_pc + 4, modulo 2^XLEN.
  4. Else: hold.
- On an applied redirect: req_epoch increments, wrapping at 2^EPOCH_W. flush pulses for one cycle.
- Redirects override valid/ready stability. The request address may change without req_ready, and the consumer discards the abandoned request by epoch.
- A redirect in HALTED updates the PC and epoch; the block stays HALTED.
- A redirect in BOOT is applied; RUN starts at the redirect target.
- Lower-priority simultaneous redirects are dropped, not queued.

## Timing
- Reset values:
  - req_pc = RESET_PC, req_epoch = 0, state = BOOT.
  - flush = 0, halted = 0, misalign_valid = 0, misalign_addr = 0.
  - req_valid = 0, since state is not RUN.
- First request: req_valid = 1 in the second cycle after rst deasserts, with req_pc = RESET_PC (if no stall or halt).
- Redirect sampled at edge N:
  - req_pc = target and epoch+1 from N+1.
  - flush high for the N+1 cycle only.
- Sequential advance: fire at edge N gives req_pc+4 visible after N.
- halt_req blocks req_valid combinationally in the same cycle. The halted output follows one cycle later.
- Reset asserted mid-operation returns all state to reset values asynchronously. A pending request is dropped.

## Configuration
- Macro: MISALIGN_TRAP_EN.
- Defined: a selected redirect target with bits [1:0] != 0 is not used.
  - req_pc <= TRAP_PC; epoch increments; flush pulses.
  - misalign_valid pulses at N+1; misalign_addr captures the target.
- Undefined: target bits [1:0] are forced to 00. misalign_valid and misalign_addr are tied to 0, and TRAP_PC is unused.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (BOOT/RUN/HALTED);
  - PC_STEP = 4;
  - redirect index constants REDIR_TRAP=0, REDIR_BRANCH=1, REDIR_JUMP=2.
- Sub-module redirect_arbiter: combinational lowest-index-wins select.
  - Inputs: redirect_valid and redirect_pc.
  - Outputs: any_valid and sel_pc.
- The top level holds the FSM, PC/epoch registers and misalign logic.

## Test plan
- Reset, then hold req_ready=1 -> req_valid rises in the second cycle; req_pc 0x0, 0x4, 0x8 on successive cycles; epoch 0.
- redirect_valid=3'b110 with targets 0x100 (source 1) and 0x200 (source 2), stall=1 -> req_pc=0x100 next cycle; epoch 0 to 1; flush is a one-cycle pulse; 0x200 is ignored.
- req_ready=0 for 3 cycles at req_pc 0x40 -> req_pc holds 0x40 with req_valid high; after ready, 0x44.
- req_pc 0xFFFF_FFFC fires -> req_pc 0x0000_0000. Four redirects -> epoch wraps 3 to 0.
- halt_req=1 plus a redirect to 0x80 -> req_valid 0, halted 1, req_pc 0x80. Release halt_req -> fetch resumes at 0x80.
- Redirect to 0x102:
  - with MISALIGN_TRAP_EN: req_pc=TRAP_PC, misalign_valid pulse, misalign_addr=0x102;
  - without it: req_pc=0x100.
